// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the operand select stage (mux_pipe_sel):
//   - default data width and default (out-of-range) value
//   - state encoding for the output register / skid buffer controller
//   - parameter sanity helper used for the elaboration-time check
// No ports (package).
package cpu_pkg;

    localparam int CPU_WIDTH = 32;
    localparam logic [CPU_WIDTH-1:0] CPU_DEFAULT_VAL = '0;

    // EMPTY: main register invalid
    // ONE:   main register valid, skid empty
    // FULL:  main and skid both hold beats, upstream is back-pressured
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    // True when the select width can address every input and NUM_IN is in range.
    function automatic bit sel_width_ok(input int num_in, input int sel_w);
        return (num_in >= 2) && (num_in <= 16) && ((1 << sel_w) >= num_in);
    endfunction

endpackage

// File: rtl/mux_pipe_sel_if.sv
// mux_pipe_sel_if
// Bundles the upstream (data/select/valid/ready/flush) and downstream
// (data/err/valid/ready/sticky) signals of the select stage.
//   in_data    NUM_IN*WIDTH flattened operands, input i at [i*WIDTH +: WIDTH]
//   sel        SEL_W        operand index, sampled on accept
//   in_valid   1            upstream beat valid
//   in_ready   1            stage can accept (registered)
//   flush      1            discard all buffered beats
//   out_data   WIDTH        selected data
//   out_err    1            beat at out_data had an out-of-range select
//   out_valid  1            out_data/out_err valid
//   out_ready  1            downstream accepts
//   err_sticky 1            any accepted out-of-range beat since reset
// Modports: master = the environment driving the stage, slave = the stage.
interface mux_pipe_sel_if
    import cpu_pkg::*;
#(
    parameter int WIDTH  = CPU_WIDTH,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;
    logic                    err_sticky;

    modport master (
        output in_data, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_err, out_valid, err_sticky
    );

    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_err, out_valid, err_sticky
    );

endinterface

// File: rtl/mux_sel_comb.sv
// mux_sel_comb
// Purely combinational NUM_IN:1 selector with range check.
//   in_data  in   NUM_IN*WIDTH  flattened operands
//   sel      in   SEL_W         operand index
//   data     out  WIDTH         in_data[sel], or DEFAULT_VAL when sel >= NUM_IN
//   err      out  1             sel >= NUM_IN
module mux_sel_comb
    import cpu_pkg::*;
#(
    parameter int               WIDTH       = CPU_WIDTH,
    parameter int               NUM_IN      = 3,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = WIDTH'(CPU_DEFAULT_VAL)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        data,
    output logic                    err
);

    // Start from the out-of-range result; a matching index overrides it, so
    // select codes beyond NUM_IN-1 fall through to DEFAULT_VAL with err set.
    always_comb begin
        data = DEFAULT_VAL;
        err  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                data = in_data[i*WIDTH +: WIDTH];
                err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_pipe_sel.sv
// mux_pipe_sel
// Parametrised NUM_IN-way, WIDTH-bit operand select stage with a registered
// output, valid/ready handshake and a 2-entry (main + skid) buffer so the
// stage sustains one beat per cycle while in_ready comes straight from a flop.
//   clk  in  rising-edge clock
//   rst  in  synchronous, active-high reset
//   bus  mux_pipe_sel_if.slave (see the interface file for the signal list)
module mux_pipe_sel
    import cpu_pkg::*;
#(
    parameter int               WIDTH       = CPU_WIDTH,
    parameter int               NUM_IN      = 3,
    parameter int               SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = WIDTH'(CPU_DEFAULT_VAL)
) (
    input logic           clk,
    input logic           rst,
    mux_pipe_sel_if.slave bus
);

    if (!sel_width_ok(NUM_IN, SEL_W)) begin : g_bad_params
        $fatal(1, "mux_pipe_sel: NUM_IN must be 2..16 and 2**SEL_W >= NUM_IN");
    end

    logic [WIDTH-1:0] pick_data;
    logic             pick_err;

    // Selection happens once, on the accept path; the buffers store the result.
    mux_sel_comb #(
        .WIDTH       (WIDTH),
        .NUM_IN      (NUM_IN),
        .SEL_W       (SEL_W),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_sel (
        .in_data (bus.in_data),
        .sel     (bus.sel),
        .data    (pick_data),
        .err     (pick_err)
    );

    pipe_state_t      state;
    logic [WIDTH-1:0] main_data;
    logic             main_err;
    logic             main_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic             ready_q;
    logic             sticky_q;

    logic accept;
    logic deliver;

    assign accept  = bus.in_valid & ready_q;
    assign deliver = main_valid & bus.out_ready;

    // Controller and datapath in one block. main_valid and ready_q are
    // registered copies of (state != EMPTY) and (state != FULL) so that every
    // output comes directly from a flop. A beat offered during flush is
    // dropped and therefore does not set the sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_EMPTY;
            main_data  <= '0;
            main_err   <= 1'b0;
            main_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
            ready_q    <= 1'b1;
            sticky_q   <= 1'b0;
        end else begin
            if (accept && pick_err && !bus.flush) begin
                sticky_q <= 1'b1;
            end

            if (bus.flush) begin
                state      <= ST_EMPTY;
                main_valid <= 1'b0;
                ready_q    <= 1'b1;
            end else begin
                unique case (state)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_data  <= pick_data;
                            main_err   <= pick_err;
                            main_valid <= 1'b1;
                            state      <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (accept && deliver) begin
                            main_data <= pick_data;
                            main_err  <= pick_err;
                        end else if (accept) begin
                            // Downstream stalled: park the new beat behind main.
                            skid_data <= pick_data;
                            skid_err  <= pick_err;
                            state     <= ST_FULL;
                            ready_q   <= 1'b0;
                        end else if (deliver) begin
                            main_valid <= 1'b0;
                            state      <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (deliver) begin
                            main_data <= skid_data;
                            main_err  <= skid_err;
                            state     <= ST_ONE;
                            ready_q   <= 1'b1;
                        end
                    end
                    default: begin
                        main_valid <= 1'b0;
                        state      <= ST_EMPTY;
                        ready_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.out_valid  = main_valid;
    assign bus.out_data   = main_data;
    assign bus.out_err    = main_err;
    assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_mux_pipe_sel.sv
// tb_mux_pipe_sel
// Directed bench for mux_pipe_sel (NUM_IN=3, WIDTH=32, DEFAULT_VAL=0xDEAD).
// Operands are fixed at A=0x11, B=0x22, C=0x33. Each vector sets the inputs,
// advances one rising edge and compares the outputs 1 time unit later.
module tb_mux_pipe_sel;

    localparam int               WIDTH  = 32;
    localparam int               NUM_IN = 3;
    localparam int               SEL_W  = 2;
    localparam logic [WIDTH-1:0] DFLT   = 32'hDEAD;

    logic clk;
    logic rst;

    int total;
    int bad;

    logic [31:0] word_of_sel [4];

    mux_pipe_sel_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

    mux_pipe_sel #(
        .WIDTH       (WIDTH),
        .NUM_IN      (NUM_IN),
        .SEL_W       (SEL_W),
        .DEFAULT_VAL (DFLT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [1:0]  sel;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] od;
        logic        oe;
        logic        ir;
        logic        st;
    } vec_t;

    vec_t vecs [11];

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [1:0] sel, input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.sel       = sel;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Data and error are only meaningful while out_valid is expected high,
    // except where the caller forces the data check (after reset).
    task automatic checkOutput(input string tag, input logic ov, input logic [31:0] od,
                               input logic oe, input logic ir, input logic st,
                               input bit force_data);
        compare({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        if (ov || force_data) begin
            compare({tag, ".out_data"}, bus.out_data, od);
            compare({tag, ".out_err"}, 32'(bus.out_err), 32'(oe));
        end
        compare({tag, ".in_ready"}, 32'(bus.in_ready), 32'(ir));
        compare({tag, ".err_sticky"}, 32'(bus.err_sticky), 32'(st));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        word_of_sel[0] = 32'h11;
        word_of_sel[1] = 32'h22;
        word_of_sel[2] = 32'h33;
        word_of_sel[3] = DFLT;

        //              iv    sel   ordy  fl    ov    od        oe    ir    st
        vecs[0]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h22,   1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 32'h11,   1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h11,   1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 32'h11,   1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 32'h33,   1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 32'h11,   1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b1};

        bus.in_data   = {32'h33, 32'h22, 32'h11};
        bus.sel       = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;

        // Single beat, stall/skid ordering, back-pressure, out-of-range select.
        for (int k = 0; k < 11; k++) begin
            applyStimulus(vecs[k].iv, vecs[k].sel, vecs[k].ordy, vecs[k].fl);
            checkOutput($sformatf("vec%0d", k), vecs[k].ov, vecs[k].od, vecs[k].oe,
                        vecs[k].ir, vecs[k].st, 1'b0);
        end

        // Streaming: one beat per cycle, no bubbles, in order.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'(i % 3), 1'b1, 1'b0);
            checkOutput($sformatf("stream%0d", i), 1'b1, word_of_sel[i % 3], 1'b0, 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput("stream_drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Flush while FULL with a concurrent offered beat.
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        checkOutput("fullfl_a", 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        checkOutput("fullfl_b", 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
        checkOutput("fullfl_flush", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput("fullfl_after", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Flush while EMPTY with a beat offered and ready high: beat is dropped.
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b1);
        checkOutput("emptyfl_flush", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput("emptyfl_after", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Flush while ONE with accept and deliver both possible.
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
        checkOutput("onefl_a", 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b1);
        checkOutput("onefl_flush", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput("onefl_after", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset mid-operation clears buffered data and the sticky error.
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        checkOutput("midrst_load", 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b1);
        checkOutput("midrst", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput("midrst_after", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_pipe_sel.md
Name: mux_pipe_sel

Overview:
- Parametrised N-way, W-bit select stage with a registered output; successor to the CPU datapath's fixed 3:1 combinational muxes.
- Sits between operand sources (regfile, ALU, memory forwarding) and a downstream consumer that may stall.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput with a registered in_ready, flush, and defined behaviour for out-of-range selects.
- The output never holds a stale value.

Parameters:
- WIDTH, 32, data width of each input and the output.
- NUM_IN, 3, number of selectable inputs (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- DEFAULT_VAL, 0, data emitted when sel >= NUM_IN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  NUM_IN*WIDTH  flattened inputs; input i is in_data[i*WIDTH +: WIDTH].
- sel  in  SEL_W  input index, sampled with in_data on accept.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept; driven directly from a flop.
- flush  in  1  discard all buffered beats.
- out_data  out  WIDTH  selected data.
- out_err  out  1  the beat at out_data had sel >= NUM_IN.
- out_valid  out  1  out_data/out_err valid.
- out_ready  in  1  downstream accepts.
- err_sticky  out  1  set by any accepted out-of-range beat; cleared only by rst.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_err=0, in_ready=1, err_sticky=0, skid entry empty.
- Accept and deliver:
  - Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
  - Selection is done at accept. The stored word is in_data[sel] when sel < NUM_IN. Otherwise it is DEFAULT_VAL with err bit = 1.
- Storage: main register (drives outputs) plus one skid register.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: both valid.
- Transitions (no flush):
  - EMPTY + accept -> ONE. The beat appears on out_data the next cycle (latency 1).
  - ONE + accept + deliver -> ONE. Main is loaded with the new beat (full throughput).
  - ONE + accept + no deliver -> FULL. The new beat goes to skid.
  - ONE + deliver, no accept -> EMPTY.
  - FULL + deliver -> ONE. Skid moves to main.
  - FULL + no deliver -> FULL. Hold.
- in_ready rule: in_ready=0 exactly while in FULL. It is registered: next in_ready = (next state != FULL).
  - Consequence: in ONE with no deliver, an accept is still legal, so the skid absorbs it.
- Outputs are stable while out_valid & !out_ready.
- No reordering: beats leave in accept order.
- Flush:
  - flush=1 -> next state EMPTY, in_ready=1, out_valid=0. Any beat offered in the same cycle is dropped.
  - Flush has priority over accept and deliver. A deliver in the flush cycle still counts downstream.
  - err_sticky is unaffected by flush.
- Reset mid-operation: rst overrides flush and all handshakes. Buffered beats are lost and the reset values apply next cycle.
- err_sticky: set in the cycle after an accepted out-of-range beat, even if that beat is later flushed.
- Data of invalid entries is don't-care internally, but out_data must read 0 after reset until the first load.

Decomposition:
- Shared package (cpu_pkg):
  - default WIDTH (32) and DEFAULT_VAL constants.
  - 2-bit state encoding constants: ST_EMPTY=0, ST_ONE=1, ST_FULL=2.
- Sub-module: mux_sel_comb.
  - Purely combinational N:1 selector with range check.
  - Outputs: selected word and err flag.
  - Instantiated once at the accept path.
- Elaboration check: SEL_W too small for NUM_IN is a fatal error.

Test Plan:
1. Reset: NUM_IN=3, WIDTH=32. rst high 2 cycles -> out_valid=0, out_data=0, in_ready=1, err_sticky=0.
2. Single beat:
   - Stimulus: in_data={C=0x33,B=0x22,A=0x11}, sel=1, in_valid 1 cycle, out_ready=1.
   - Response: next cycle out_valid=1, out_data=0x22, out_err=0. Following cycle out_valid=0.
3. Stall and skid:
   - Stimulus: out_ready=0, offer sel=0 then sel=2 on consecutive cycles.
   - Response: both accepted; in_ready=0 from the 3rd cycle. out_data holds 0x11.
   - Then raise out_ready: 0x11, then 0x33, in order. in_ready returns to 1 after the first deliver.
4. Out-of-range:
   - Stimulus: sel=3 with NUM_IN=3, DEFAULT_VAL=0xDEAD.
   - Response: out_data=0xDEAD, out_err=1, err_sticky=1 and remaining 1 until rst.
5. Streaming: in_valid=out_ready=1 for 8 cycles with sel cycling 0,1,2 -> 8 consecutive output beats in order, no bubbles after the first.
6. Flush in FULL: flush=1 concurrent with in_valid=1 -> next cycle out_valid=0, in_ready=1. The concurrent beat never appears.
